// File: rtl/eth_mdio_ctrl.sv
`default_nettype none
// eth_mdio_ctrl -- Clause 22 MDIO master: one 64-slot management frame per command,
// MDC = Eth_Clk / (2*CLK_DIV). Rev 1.0
module eth_mdio_ctrl #(
  parameter int CLK_DIV = 10
) (
  input  logic        Eth_Clk,
  input  logic        Eth_Rst,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic        Cmd_Write,
  input  logic [4:0]  Cmd_Phy_Addr,
  input  logic [4:0]  Cmd_Reg_Addr,
  input  logic [15:0] Cmd_Wdata,
  output logic        Rsp_Valid,
  output logic [15:0] Rsp_Rdata,
  output logic        Rsp_Err,
  output logic        Busy,
  output logic        MDC_Clk,
  output logic        Mdio_O,
  output logic        Mdio_Oe,
  input  logic        Mdio_I
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PEN  = DW'(CLK_DIV - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] div_cnt;
  logic [5:0]    slot;
  logic [5:0]    slot_nxt;
  logic          mdc;
  logic          mdio_o;
  logic          mdio_oe;
  logic          wr;
  logic [31:0]   frame_lo;
  logic [15:0]   rd_shift;
  logic          ta_err;
  logic          rsp_valid;
  logic [15:0]  rsp_rdata;
  logic          rsp_err;
  logic          accept;
  logic          low_end;
  logic          slot_end;

  assign accept   = (state == S_IDLE) & Cmd_Valid & ~Eth_Rst;
  assign low_end  = ~mdc & (div_cnt == DIV_LAST);
  assign slot_end = mdc & (div_cnt == DIV_LAST);
  assign slot_nxt = slot + 6'd1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (Cmd_Valid) state_nxt = S_PRE;
      S_PRE:  if (slot_end && slot == 6'd31) state_nxt = S_HDR;
      S_HDR:  if (slot_end && slot == 6'd45) state_nxt = S_TA;
      S_TA:   if (slot_end && slot == 6'd47) state_nxt = S_DATA;
      // DONE is the final high-phase cycle of slot 63, so the response cycle is already IDLE
      S_DATA: if (mdc && div_cnt == DIV_PEN && slot == 6'd63) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Eth_Clk) begin
    if (Eth_Rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge Eth_Clk) begin
    rsp_valid <= 1'b0;
    if (Eth_Rst) begin
      div_cnt   <= '0;
      slot      <= '0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      wr        <= 1'b0;
      frame_lo  <= '0;
      rd_shift  <= '0;
      ta_err    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      div_cnt  <= '0;
      slot     <= '0;
      mdc      <= 1'b0;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b1;
      wr       <= Cmd_Write;
      // ST, OP, PHYAD, REGAD, TA, DATA; read TA/DATA bits are never driven
      frame_lo <= {2'b01, (Cmd_Write ? 2'b01 : 2'b10), Cmd_Phy_Addr, Cmd_Reg_Addr,
                   (Cmd_Write ? 2'b10 : 2'b11), (Cmd_Write ? Cmd_Wdata : 16'hFFFF)};
      rd_shift <= '0;
      ta_err   <= 1'b0;
    end else if (state == S_DONE) begin
      div_cnt   <= '0;
      slot      <= '0;
      mdc       <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_valid <= 1'b1;
      rsp_rdata <= wr ? 16'h0000 : rd_shift;
      rsp_err   <= ~wr & ta_err;
    end else if (state != S_IDLE) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        mdc     <= ~mdc;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (low_end && state == S_TA && slot == 6'd47) ta_err <= Mdio_I;
      if (low_end && state == S_DATA) rd_shift <= {rd_shift[14:0], Mdio_I};
      if (slot_end) begin
        slot    <= slot_nxt;
        mdio_oe <= wr | (slot_nxt < 6'd46);
        mdio_o  <= (slot_nxt < 6'd32) ? 1'b1 : frame_lo[~slot_nxt[4:0]];
      end
    end
  end

  assign Cmd_Ready = (state == S_IDLE) & ~Eth_Rst;
  assign Busy      = (state != S_IDLE);
  assign MDC_Clk   = mdc;
  assign Mdio_O    = mdio_o;
  assign Mdio_Oe   = mdio_oe;
  assign Rsp_Valid = rsp_valid;
  assign Rsp_Rdata = rsp_rdata;
  assign Rsp_Err   = rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_eth_mdio_ctrl.sv
`default_nettype none
// tb_eth_mdio_ctrl -- directed self-checking bench for eth_mdio_ctrl with CLK_DIV = 2.
module tb_eth_mdio_ctrl;

  localparam int D     = 2;
  localparam int FRAME = 128 * D;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_in;

  logic        nxt_write;
  logic [4:0]  nxt_phy;
  logic [4:0]  nxt_reg;
  logic [15:0] nxt_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eth_mdio_ctrl #(.CLK_DIV(D)) dut (
    .Eth_Clk      (clk),
    .Eth_Rst      (rst),
    .Cmd_Valid    (cmd_valid),
    .Cmd_Ready    (cmd_ready),
    .Cmd_Write    (cmd_write),
    .Cmd_Phy_Addr (cmd_phy),
    .Cmd_Reg_Addr (cmd_reg),
    .Cmd_Wdata    (cmd_wdata),
    .Rsp_Valid    (rsp_valid),
    .Rsp_Rdata    (rsp_rdata),
    .Rsp_Err      (rsp_err),
    .Busy         (busy),
    .MDC_Clk      (mdc),
    .Mdio_O       (mdio_o),
    .Mdio_Oe      (mdio_oe),
    .Mdio_I       (mdio_in)
  );

  // Caller leaves cmd_valid high in an IDLE cycle; returns in the response cycle.
  // mode 0: drop valid; 1: scramble fields and hold valid while busy; 2: present nxt_* command.
  task automatic check_frame(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input logic phy_on,
                             input logic [15:0] phy_data, input int mode);
    logic [63:0] fr;
    logic [15:0] exp_rd;
    logic        exp_err;
    logic        exp_mdc;
    logic        exp_oe;
    int          k;
    fr = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), pa, ra, (wr ? 2'b10 : 2'b11),
          (wr ? wd : 16'hFFFF)};
    exp_rd  = wr ? 16'h0000 : (phy_on ? phy_data : 16'hFFFF);
    exp_err = ~wr & ~phy_on;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_ready got=%b want=1", cmd_ready);
    end
    @(posedge clk); #1;
    if (mode == 0) begin
      cmd_valid = 1'b0;
    end else if (mode == 1) begin
      cmd_valid = 1'b1;
      cmd_write = ~wr;
      cmd_phy   = ~pa;
      cmd_reg   = ~ra;
      cmd_wdata = ~wd;
    end else begin
      cmd_valid = 1'b1;
      cmd_write = nxt_write;
      cmd_phy   = nxt_phy;
      cmd_reg   = nxt_reg;
      cmd_wdata = nxt_wdata;
    end
    for (int c = 1; c <= FRAME + 1; c++) begin
      if (c <= FRAME) begin
        k       = (c - 1) / (2 * D);
        exp_mdc = ((c - 1) % (2 * D)) >= D;
        exp_oe  = wr | (k < 46);
        if (!wr && phy_on && k == 47)      mdio_in = 1'b0;
        else if (!wr && phy_on && k >= 48) mdio_in = phy_data[63 - k];
        else                               mdio_in = 1'b1;
        total++;
        if (mdc !== exp_mdc) begin
          bad++;
          $display("FAIL mdc cyc=%0d got=%b want=%b", c, mdc, exp_mdc);
        end
        total++;
        if (mdio_oe !== exp_oe) begin
          bad++;
          $display("FAIL mdio_oe cyc=%0d slot=%0d got=%b want=%b", c, k, mdio_oe, exp_oe);
        end
        if (exp_oe) begin
          total++;
          if (mdio_o !== fr[63 - k]) begin
            bad++;
            $display("FAIL mdio_o cyc=%0d slot=%0d got=%b want=%b", c, k, mdio_o, fr[63 - k]);
          end
        end
        total++;
        if ({busy, cmd_ready, rsp_valid} !== 3'b100) begin
          bad++;
          $display("FAIL busy_ready_valid cyc=%0d got=%b want=100", c, {busy, cmd_ready, rsp_valid});
        end
        if (mode == 1 && c == 100) begin
          cmd_phy   = 5'h15;
          cmd_wdata = 16'h0F0F;
        end
        if (mode == 1 && c == FRAME) cmd_valid = 1'b0;
        @(posedge clk); #1;
      end else begin
        mdio_in = 1'b1;
        total++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b110) begin
          bad++;
          $display("FAIL rsp_cycle_flags got=%b want=110", {rsp_valid, cmd_ready, busy});
        end
        total++;
        if (rsp_rdata !== exp_rd) begin
          bad++;
          $display("FAIL rsp_rdata got=%h want=%h", rsp_rdata, exp_rd);
        end
        total++;
        if (rsp_err !== exp_err) begin
          bad++;
          $display("FAIL rsp_err got=%b want=%b", rsp_err, exp_err);
        end
        total++;
        if ({mdc, mdio_oe, mdio_o} !== 3'b001) begin
          bad++;
          $display("FAIL rsp_cycle_line got=%b want=001", {mdc, mdio_oe, mdio_o});
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b0;
    mdio_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, busy, rsp_valid, rsp_err, mdc, mdio_oe, mdio_o} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_held got=%b want=0000001",
               {cmd_ready, busy, rsp_valid, rsp_err, mdc, mdio_oe, mdio_o});
    end
    total++;
    if (rsp_rdata !== 16'h0000) begin
      bad++;
      $display("FAIL reset_rdata got=%h want=0000", rsp_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({cmd_ready, busy, rsp_valid, rsp_err, mdc, mdio_oe, mdio_o} !== 7'b1000001) begin
      bad++;
      $display("FAIL reset_released got=%b want=1000001",
               {cmd_ready, busy, rsp_valid, rsp_err, mdc, mdio_oe, mdio_o});
    end
  endtask

  task automatic test_write;
    cmd_write = 1'b1; cmd_phy = 5'd1; cmd_reg = 5'd0; cmd_wdata = 16'h1140;
    cmd_valid = 1'b1;
    check_frame(1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_read;
    cmd_write = 1'b0; cmd_phy = 5'd1; cmd_reg = 5'd2; cmd_wdata = 16'hDEAD;
    cmd_valid = 1'b1;
    check_frame(1'b0, 5'd1, 5'd2, 16'hDEAD, 1'b1, 16'h0022, 0);
  endtask

  task automatic test_read_nophy;
    cmd_write = 1'b0; cmd_phy = 5'd3; cmd_reg = 5'd1; cmd_wdata = 16'h0000;
    cmd_valid = 1'b1;
    check_frame(1'b0, 5'd3, 5'd1, 16'h0000, 1'b0, 16'h0000, 0);
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 16'hFFFF}) begin
      bad++;
      $display("FAIL nophy_after got=%b/%b/%h want=0/1/ffff", rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic saw_valid;
    cmd_write = 1'b0; cmd_phy = 5'd1; cmd_reg = 5'd2;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2 * D * 20) @(posedge clk);
    #1;
    total++;
    if ({busy, mdc} !== 2'b10) begin
      bad++;
      $display("FAIL mid_slot20 got=%b want=10", {busy, mdc});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({cmd_ready, busy, rsp_valid, rsp_err, mdc, mdio_oe, mdio_o} !== 7'b0000001) begin
      bad++;
      $display("FAIL mid_reset_line got=%b want=0000001",
               {cmd_ready, busy, rsp_valid, rsp_err, mdc, mdio_oe, mdio_o});
    end
    total++;
    if (rsp_rdata !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset_rdata got=%h want=0000", rsp_rdata);
    end
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_quiet got=%b want=0", saw_valid);
    end
    test_write();
  endtask

  task automatic test_back_to_back;
    cmd_write = 1'b0; cmd_phy = 5'd2; cmd_reg = 5'd3; cmd_wdata = 16'h0000;
    nxt_write = 1'b1; nxt_phy = 5'h1F; nxt_reg = 5'h1F; nxt_wdata = 16'hBEEF;
    cmd_valid = 1'b1;
    check_frame(1'b0, 5'd2, 5'd3, 16'h0000, 1'b1, 16'hA5C3, 2);
    check_frame(1'b1, 5'h1F, 5'h1F, 16'hBEEF, 1'b0, 16'h0000, 0);
  endtask

  task automatic test_stability;
    cmd_write = 1'b1; cmd_phy = 5'd3; cmd_reg = 5'd4; cmd_wdata = 16'h5AA5;
    cmd_valid = 1'b1;
    check_frame(1'b1, 5'd3, 5'd4, 16'h5AA5, 1'b0, 16'h0000, 1);
    @(posedge clk); #1;
    total++;
    if ({busy, rsp_valid, cmd_ready} !== 3'b001) begin
      bad++;
      $display("FAIL stability_no_extra got=%b want=001", {busy, rsp_valid, cmd_ready});
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_phy = '0;
    cmd_reg = '0;
    cmd_wdata = '0;
    mdio_in = 1'b1;
    nxt_write = 1'b0;
    nxt_phy = '0;
    nxt_reg = '0;
    nxt_wdata = '0;
    test_reset();
    test_write();
    test_read();
    test_read_nophy();
    test_reset_mid();
    test_back_to_back();
    test_stability();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
